// File: rtl/bram_rd_sequencer.sv
// bram_rd_sequencer: read-side controller for the input/weight BRAM pair.
// It walks the output blocks of matrix C (r outer, c, k inner) and issues
// paired reads on port B of both BRAMs. Because the BRAMs have a 1-cycle
// read latency, each read's data is captured with its {last_k, flag} tag into
// a 2-entry FIFO. The FIFO drains to the systolic core over a valid/ready
// stream. done pulses for one cycle after the final beat has been accepted.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   one-cycle pulse, starts a pass from IDLE
//   in_enb/in_addrb         input BRAM port B enable/address
//   in_doutb                input BRAM read data (1-cycle latency)
//   wb_enb/wb_addrb         weight BRAM port B enable/address
//   wb_doutb                weight BRAM read data (1-cycle latency)
//   out_valid/out_ready     output stream handshake
//   out_in_data/out_w_data  paired input/weight words
//   out_last_k              beat is the last inner step of its block
//   out_flag                output-block index of the beat
//   busy, done              pass in progress / end-of-pass pulse
module bram_rd_sequencer #(
    parameter int WIDTH             = 16,
    parameter int CHUNK_SIZE        = 4,
    parameter int NUM_CORES         = 2,
    parameter int BLOCK_SIZE        = 2,
    parameter int INNER_DIMENSION   = 4,
    parameter int I_OUTER_DIMENSION = 6,
    parameter int W_OUTER_DIMENSION = 6,
    parameter int ADDR_WIDTH_I      = 14,
    parameter int ADDR_WIDTH_W      = 12,
    parameter int MAX_FLAG          = (I_OUTER_DIMENSION / BLOCK_SIZE) *
                                      (W_OUTER_DIMENSION / BLOCK_SIZE)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    output logic                                  in_enb,
    output logic [ADDR_WIDTH_I-1:0]               in_addrb,
    input  logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] in_doutb,
    output logic                                  wb_enb,
    output logic [ADDR_WIDTH_W-1:0]               wb_addrb,
    input  logic [WIDTH*CHUNK_SIZE-1:0]           wb_doutb,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] out_in_data,
    output logic [WIDTH*CHUNK_SIZE-1:0]           out_w_data,
    output logic                                  out_last_k,
    output logic [$clog2(MAX_FLAG+1)-1:0]         out_flag,
    output logic                                  busy,
    output logic                                  done
);

    localparam int K_STEPS = INNER_DIMENSION / BLOCK_SIZE;
    localparam int ROWS    = I_OUTER_DIMENSION / BLOCK_SIZE;
    localparam int COLS    = W_OUTER_DIMENSION / BLOCK_SIZE;
    localparam int KW      = $clog2(K_STEPS > 1 ? K_STEPS : 2);
    localparam int RW      = $clog2(ROWS > 1 ? ROWS : 2);
    localparam int CW      = $clog2(COLS > 1 ? COLS : 2);
    localparam int FW      = $clog2(MAX_FLAG + 1);
    localparam int IW      = WIDTH * CHUNK_SIZE * NUM_CORES;
    localparam int WW      = WIDTH * CHUNK_SIZE;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [KW-1:0]   k_cnt;
    logic [CW-1:0]   c_cnt;
    logic [RW-1:0]   r_cnt;
    logic [FW-1:0]   flag_cnt;
    logic            issue, clear, pop, push, room;
    logic            last_k, last_beat;
    logic            inflight;
    logic            tag_last;
    logic [FW-1:0]   tag_flag;
    logic [IW-1:0]   f_in   [2];
    logic [WW-1:0]   f_w    [2];
    logic            f_last [2];
    logic [FW-1:0]   f_flag [2];
    logic            wr_ptr, rd_ptr;
    logic [1:0]      count;
    logic [2:0]      occ;

    assign last_k    = (k_cnt == KW'(K_STEPS - 1));
    assign last_beat = last_k && (c_cnt == CW'(COLS - 1)) && (r_cnt == RW'(ROWS - 1));

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid & out_ready;
    assign push      = inflight;
    // Entries already buffered plus the read still in the BRAM pipe, less the
    // beat leaving this cycle, must leave a free slot for the new read.
    assign occ       = 3'(count) + 3'(inflight) - 3'(pop);
    assign room      = (occ < 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        clear     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    clear     = 1'b1;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (room) begin
                    issue = 1'b1;
                    if (last_beat) state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (count == 2'd0 && !inflight) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign in_enb   = issue;
    assign wb_enb   = issue;
    assign in_addrb = issue ? ADDR_WIDTH_I'(r_cnt * K_STEPS + k_cnt) : '0;
    assign wb_addrb = issue ? ADDR_WIDTH_W'(c_cnt * K_STEPS + k_cnt) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_cnt    <= '0;
            c_cnt    <= '0;
            r_cnt    <= '0;
            flag_cnt <= '0;
        end else if (clear) begin
            k_cnt    <= '0;
            c_cnt    <= '0;
            r_cnt    <= '0;
            flag_cnt <= '0;
        end else if (issue) begin
            if (!last_k) begin
                k_cnt <= k_cnt + 1'b1;
            end else begin
                k_cnt    <= '0;
                flag_cnt <= flag_cnt + 1'b1;
                if (c_cnt != CW'(COLS - 1)) begin
                    c_cnt <= c_cnt + 1'b1;
                end else begin
                    c_cnt <= '0;
                    r_cnt <= (r_cnt == RW'(ROWS - 1)) ? '0 : r_cnt + 1'b1;
                end
            end
        end
    end

    // Tag travels alongside the BRAM read so it lines up with the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            tag_last <= 1'b0;
            tag_flag <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                tag_last <= last_k;
                tag_flag <= flag_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                f_in[i]   <= '0;
                f_w[i]    <= '0;
                f_last[i] <= 1'b0;
                f_flag[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                f_in[wr_ptr]   <= in_doutb;
                f_w[wr_ptr]    <= wb_doutb;
                f_last[wr_ptr] <= tag_last;
                f_flag[wr_ptr] <= tag_flag;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign out_in_data = f_in[rd_ptr];
    assign out_w_data  = f_w[rd_ptr];
    assign out_last_k  = f_last[rd_ptr];
    assign out_flag    = f_flag[rd_ptr];

endmodule

// File: tb/tb_bram_rd_sequencer.sv
// Scoreboard bench for bram_rd_sequencer: the expected read-address and beat
// sequences are generated from the block iteration order and pushed into
// queues at the start of each pass; a negedge monitor pops and compares.
module tb_bram_rd_sequencer;

    localparam int K_STEPS = 2;
    localparam int ROWS    = 3;
    localparam int COLS    = 3;
    localparam int BEATS   = ROWS * COLS * K_STEPS;
    localparam int IW      = 128;
    localparam int WW      = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            out_ready = 1'b0;
    logic            in_enb, wb_enb, out_valid, out_last_k, busy, done;
    logic [13:0]     in_addrb;
    logic [11:0]     wb_addrb;
    logic [IW-1:0]   in_doutb = '0;
    logic [WW-1:0]   wb_doutb = '0;
    logic [IW-1:0]   out_in_data;
    logic [WW-1:0]   out_w_data;
    logic [3:0]      out_flag;

    bram_rd_sequencer #(
        .WIDTH(16), .CHUNK_SIZE(4), .NUM_CORES(2), .BLOCK_SIZE(2),
        .INNER_DIMENSION(4), .I_OUTER_DIMENSION(6), .W_OUTER_DIMENSION(6),
        .ADDR_WIDTH_I(14), .ADDR_WIDTH_W(12)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_enb(in_enb), .in_addrb(in_addrb), .in_doutb(in_doutb),
        .wb_enb(wb_enb), .wb_addrb(wb_addrb), .wb_doutb(wb_doutb),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_in_data(out_in_data), .out_w_data(out_w_data),
        .out_last_k(out_last_k), .out_flag(out_flag),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ia;
        int wa;
        bit lk;
        int fl;
    } beat_t;

    beat_t        addr_q[$];
    beat_t        beat_q[$];
    int           asserts = 0;
    int           failures = 0;
    int           cyc = 0;
    int           issued = 0;
    int           accepted = 0;
    int           done_cnt = 0;
    int           first_cyc, last_cyc, done_cyc, start_cyc;
    logic [15:0]  in_salt = '0;
    logic [15:0]  w_salt = '0;
    bit           stall_prev = 0;
    bit           busy_prev = 0;
    logic [255:0] held;

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM contents: each lane holds its address, salted per pass.
    function automatic logic [IW-1:0] in_word(input int a);
        logic [IW-1:0] v;
        for (int j = 0; j < 8; j++) v[j*16 +: 16] = 16'(a) ^ in_salt ^ 16'(j << 12);
        return v;
    endfunction

    function automatic logic [WW-1:0] w_word(input int a);
        logic [WW-1:0] v;
        for (int j = 0; j < 4; j++) v[j*16 +: 16] = 16'(a) ^ w_salt ^ 16'(j << 12);
        return v;
    endfunction

    always @(posedge clk) begin
        if (in_enb) in_doutb <= in_word(int'(in_addrb));
        if (wb_enb) wb_doutb <= w_word(int'(wb_addrb));
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        asserts++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (rst_n) begin
            check("enb_pair", in_enb, wb_enb);
            check("occupancy_le_2", (issued - accepted) <= 2, 1);
            if (in_enb) begin
                if (addr_q.size() == 0) begin
                    check("spurious_issue", 1, 0);
                end else begin
                    e = addr_q.pop_front();
                    check("in_addrb", in_addrb, e.ia);
                    check("wb_addrb", wb_addrb, e.wa);
                end
                issued++;
            end
            if (stall_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_payload", {out_in_data, out_w_data, out_last_k, out_flag}, held);
            end
            if (out_valid && out_ready) begin
                if (beat_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    e = beat_q.pop_front();
                    check("out_in_data", out_in_data, in_word(e.ia));
                    check("out_w_data", out_w_data, w_word(e.wa));
                    check("out_last_k", out_last_k, e.lk);
                    check("out_flag", out_flag, e.fl);
                end
                if (accepted == 0) first_cyc = cyc;
                last_cyc = cyc;
                accepted++;
            end
            stall_prev = out_valid && !out_ready;
            held = {out_in_data, out_w_data, out_last_k, out_flag};
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_low_at_done", busy, 0);
                check("busy_high_before_done", busy_prev, 1);
            end
            busy_prev = busy;
        end else begin
            stall_prev = 0;
            busy_prev = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks();
        check("rst_in_enb", in_enb, 0);
        check("rst_in_addrb", in_addrb, 0);
        check("rst_wb_enb", wb_enb, 0);
        check("rst_wb_addrb", wb_addrb, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last_k", out_last_k, 0);
        check("rst_out_flag", out_flag, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
    endtask

    function automatic logic ready_for(input int mode, input int i);
        case (mode)
            0: return 1'b1;
            1: return (i % 4 == 0) || (i % 4 == 3);
            2: return i > 10;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic prep_pass();
        beat_t b;
        addr_q.delete();
        beat_q.delete();
        issued = 0;
        accepted = 0;
        in_salt = 16'($urandom);
        w_salt = 16'($urandom);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                for (int k = 0; k < K_STEPS; k++) begin
                    b.ia = r * K_STEPS + k;
                    b.wa = c * K_STEPS + k;
                    b.lk = (k == K_STEPS - 1);
                    b.fl = r * COLS + c;
                    addr_q.push_back(b);
                    beat_q.push_back(b);
                end
    endtask

    task automatic run_pass(input int mode, input bit poke, input bit rst_mid);
        int d0;
        bit aborted;
        d0 = done_cnt;
        aborted = 0;
        prep_pass();
        start = 1'b1;
        start_cyc = cyc;
        out_ready = ready_for(mode, 0);
        for (int i = 1; i < 400; i++) begin
            step();
            start = 1'b0;
            out_ready = ready_for(mode, i);
            if (poke && (i == 8 || done)) start = 1'b1;
            if (mode == 2 && i == 11) check("stall_issue_cap", issued, 2);
            if (rst_mid && accepted >= 7 && !out_ready && out_valid) begin
                #2 rst_n = 1'b0;
                #1 reset_checks();
                aborted = 1;
                break;
            end
            if (done_cnt != d0) break;
        end
        start = 1'b0;
        if (rst_mid) check("reset_point_reached", aborted, 1);
        if (aborted) begin
            addr_q.delete();
            beat_q.delete();
            step();
            step();
            rst_n = 1'b1;
            for (int i = 0; i < 6; i++) step();
            check("no_done_after_reset", done_cnt, d0);
            check("idle_after_reset", busy, 0);
            return;
        end
        for (int i = 0; i < 4; i++) begin
            step();
            check("idle_after_done", {busy, in_enb}, 0);
        end
        check("beats_accepted", accepted, BEATS);
        check("reads_issued", issued, BEATS);
        check("done_once", done_cnt - d0, 1);
        check("beat_q_empty", beat_q.size(), 0);
        if (mode == 0) begin
            check("first_beat_latency", first_cyc - start_cyc, 3);
            check("back_to_back", last_cyc - first_cyc, BEATS - 1);
            check("done_after_last", done_cyc - last_cyc, 2);
        end
    endtask

    initial begin
        step();
        reset_checks();
        step();
        rst_n = 1'b1;
        step();
        reset_checks();
        run_pass(0, 0, 0);
        run_pass(1, 0, 0);
        run_pass(2, 0, 0);
        run_pass(1, 0, 1);
        run_pass(0, 0, 0);
        run_pass(0, 1, 0);
        for (int n = 0; n < 3; n++) run_pass(3, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
